// File: rtl/el2_dccm_bank_responder.sv
// el2_dccm_bank_responder: banked DCCM RAM, 1-cycle reads, post-reset zero-fill.
// Optional DCCM_ERR_INJ_EN adds a one-shot read error injector per arm pulse.
module el2_dccm_bank_responder #(
  parameter int NUM_BANKS  = 4,
  parameter int INDEX_BITS = 10,
  parameter int DATA_WIDTH = 32,
  parameter int ECC_WIDTH  = 7,
  parameter logic [ECC_WIDTH-1:0] INIT_ECC = 7'h00
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [NUM_BANKS-1:0]            dccm_clken,
  input  logic [NUM_BANKS-1:0]            dccm_wren_bank,
  input  logic [NUM_BANKS*INDEX_BITS-1:0] dccm_addr_bank,
  input  logic [NUM_BANKS*DATA_WIDTH-1:0] dccm_wr_data_bank,
  input  logic [NUM_BANKS*ECC_WIDTH-1:0]  dccm_wr_ecc_bank,
  output logic [NUM_BANKS*DATA_WIDTH-1:0] dccm_bank_dout,
  output logic [NUM_BANKS*ECC_WIDTH-1:0]  dccm_bank_ecc,
`ifdef DCCM_ERR_INJ_EN
  input  logic                            err_inj_arm,
  input  logic [$clog2(NUM_BANKS)-1:0]    err_inj_bank,
  input  logic [DATA_WIDTH+ECC_WIDTH-1:0] err_inj_mask,
`endif
  output logic                            init_done
);

  localparam int DEPTH = 1 << INDEX_BITS;
  localparam int RW    = DATA_WIDTH + ECC_WIDTH;
  localparam logic [INDEX_BITS:0] LAST_ROW =
    (INDEX_BITS+1)'(DEPTH - 1);

  typedef enum logic {FILL, READY} state_t;

  state_t state_q, state_d;
  logic [INDEX_BITS:0] fill_cnt_q, fill_cnt_d;
  logic init_done_q, init_done_d;
  logic [NUM_BANKS-1:0][RW-1:0] rd_q, rd_d;

  logic [NUM_BANKS-1:0]                 we;
  logic [NUM_BANKS-1:0][INDEX_BITS-1:0] waddr;
  logic [NUM_BANKS-1:0][RW-1:0]         wdata;

  logic [RW-1:0] mem [NUM_BANKS][DEPTH];

`ifdef DCCM_ERR_INJ_EN
  localparam int BW = $clog2(NUM_BANKS);
  logic          armed_q, armed_d;
  logic [BW-1:0] inj_bank_q, inj_bank_d;
  logic [RW-1:0] inj_mask_q, inj_mask_d;
`endif

  // Next-state: fill sweep, then per-bank host reads/writes.
  always_comb begin
    state_d     = state_q;
    fill_cnt_d  = fill_cnt_q;
    init_done_d = init_done_q;
    rd_d        = rd_q;
    we          = '0;
    waddr       = '0;
    wdata       = '0;
`ifdef DCCM_ERR_INJ_EN
    armed_d     = armed_q;
    inj_bank_d  = inj_bank_q;
    inj_mask_d  = inj_mask_q;
`endif
    unique case (state_q)
      FILL: begin
        we = '1;
        for (int b = 0; b < NUM_BANKS; b++) begin
          waddr[b] = fill_cnt_q[INDEX_BITS-1:0];
          wdata[b] = {INIT_ECC, {DATA_WIDTH{1'b0}}};
        end
        fill_cnt_d = fill_cnt_q + 1'b1;
        if (fill_cnt_q == LAST_ROW) begin
          state_d     = READY;
          init_done_d = 1'b1;
        end
      end
      READY: begin
        for (int b = 0; b < NUM_BANKS; b++) begin
          if (dccm_clken[b]) begin
            if (dccm_wren_bank[b]) begin
              we[b]    = 1'b1;
              waddr[b] =
                dccm_addr_bank[b*INDEX_BITS +: INDEX_BITS];
              wdata[b] = {
                dccm_wr_ecc_bank[b*ECC_WIDTH +: ECC_WIDTH],
                dccm_wr_data_bank[b*DATA_WIDTH +: DATA_WIDTH]};
            end else begin
`ifdef DCCM_ERR_INJ_EN
              if (armed_q && (inj_bank_q == BW'(b))) begin
                rd_d[b] = inj_mask_q ^ mem[b][
                  dccm_addr_bank[b*INDEX_BITS +: INDEX_BITS]];
                armed_d = 1'b0;
              end else begin
                rd_d[b] = mem[b][
                  dccm_addr_bank[b*INDEX_BITS +: INDEX_BITS]];
              end
`else
              rd_d[b] = mem[b][
                dccm_addr_bank[b*INDEX_BITS +: INDEX_BITS]];
`endif
            end
          end
        end
`ifdef DCCM_ERR_INJ_EN
        // A new arm wins over a same-cycle consuming read.
        if (err_inj_arm) begin
          armed_d    = 1'b1;
          inj_bank_d = err_inj_bank;
          inj_mask_d = err_inj_mask;
        end
`endif
      end
    endcase
  end

  // Control and read-output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= FILL;
      fill_cnt_q  <= '0;
      init_done_q <= 1'b0;
      rd_q        <= '0;
`ifdef DCCM_ERR_INJ_EN
      armed_q     <= 1'b0;
      inj_bank_q  <= '0;
      inj_mask_q  <= '0;
`endif
    end else begin
      state_q     <= state_d;
      fill_cnt_q  <= fill_cnt_d;
      init_done_q <= init_done_d;
      rd_q        <= rd_d;
`ifdef DCCM_ERR_INJ_EN
      armed_q     <= armed_d;
      inj_bank_q  <= inj_bank_d;
      inj_mask_q  <= inj_mask_d;
`endif
    end
  end

  // Storage array; never reset, cleared by the fill sweep.
  always_ff @(posedge clk) begin
    for (int b = 0; b < NUM_BANKS; b++) begin
      if (!rst && we[b]) begin
        mem[b][waddr[b]] <= wdata[b];
      end
    end
  end

  for (genvar g = 0; g < NUM_BANKS; g++) begin : g_out
    assign dccm_bank_dout[g*DATA_WIDTH +: DATA_WIDTH] =
      rd_q[g][DATA_WIDTH-1:0];
    assign dccm_bank_ecc[g*ECC_WIDTH +: ECC_WIDTH] =
      rd_q[g][RW-1:DATA_WIDTH];
  end

  assign init_done = init_done_q;

endmodule
